// File: rtl/alu_pkg.sv
// Shared ALU definitions: unit-id encoding and the collector entry layout {unit, carry, data}.
package alu_pkg;

  localparam logic [1:0] UNIT_ARITH = 2'd0;
  localparam logic [1:0] UNIT_LOGIC = 2'd1;
  localparam logic [1:0] UNIT_CMP   = 2'd2;
  localparam logic [1:0] UNIT_SHIFT = 2'd3;

  localparam int ALU_DATA_WIDTH = 8;

  // Entry width for a given result width: 2-bit unit id + carry + data.
  function automatic int entry_width(input int dw);
    return dw + 3;
  endfunction

  typedef struct packed {
    logic [1:0]                unit;
    logic                      carry;
    logic [ALU_DATA_WIDTH-1:0] data;
  } alu_entry_t;

endpackage

// File: rtl/alu_sync_fifo.sv
// Generic synchronous FIFO with registered occupancy count. A push into a full FIFO is
// accepted only when a pop happens in the same cycle. The head reads as zero while empty.
module alu_sync_fifo #(
  parameter int WIDTH = 11,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [AW-1:0]               wr_ptr, rd_ptr;
  logic                        do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers are AW bits wide, so wrap modulo DEPTH comes for free.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/alu_result_collector.sv
// Tags ALU unit results with their source id and queues them for a valid/ready consumer.
// Optional ALU_COLLECT_DROPCNT_EN adds a saturating DROP_CNT output.
module alu_result_collector
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic [DATA_WIDTH-1:0]       Arith_OUT,
  input  logic [DATA_WIDTH-1:0]       Logic_OUT,
  input  logic [DATA_WIDTH-1:0]       CMP_OUT,
  input  logic [DATA_WIDTH-1:0]       Shift_OUT,
  input  logic                        Carry_OUT,
  input  logic                        Arith_Flag,
  input  logic                        Logic_Flag,
  input  logic                        CMP_Flag,
  input  logic                        Shift_Flag,
  input  logic                        CLR_ERR,
  input  logic                        OUT_READY,
  output logic                        OUT_VALID,
  output logic [DATA_WIDTH-1:0]       OUT_DATA,
  output logic                        OUT_CARRY,
  output logic [1:0]                  OUT_UNIT,
  output logic [$clog2(FIFO_DEPTH):0] COUNT,
  output logic                        OVERFLOW,
  output logic                        MULTI_ERR
`ifdef ALU_COLLECT_DROPCNT_EN
  ,
  output logic [7:0]                  DROP_CNT
`endif
);
  localparam int EW = entry_width(DATA_WIDTH);

  logic [3:0]            flags;
  logic                  push_req, multi, ovf_drop;
  logic [1:0]            sel_unit;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  sel_carry;
  logic [EW-1:0]         entry, head;
  logic                  empty, full;

  assign flags    = {Shift_Flag, CMP_Flag, Logic_Flag, Arith_Flag};
  assign push_req = $onehot(flags);
  assign multi    = !$onehot0(flags);

  always_comb begin
    sel_unit  = UNIT_ARITH;
    sel_data  = Arith_OUT;
    sel_carry = Carry_OUT;
    if (Logic_Flag) begin
      sel_unit = UNIT_LOGIC; sel_data = Logic_OUT; sel_carry = 1'b0;
    end else if (CMP_Flag) begin
      sel_unit = UNIT_CMP;   sel_data = CMP_OUT;   sel_carry = 1'b0;
    end else if (Shift_Flag) begin
      sel_unit = UNIT_SHIFT; sel_data = Shift_OUT; sel_carry = 1'b0;
    end
  end

  assign entry = {sel_unit, sel_carry, sel_data};

  alu_sync_fifo #(.WIDTH(EW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (CLK),
    .rst   (RST),
    .push  (push_req),
    .pop   (OUT_READY),
    .din   (entry),
    .dout  (head),
    .empty (empty),
    .full  (full),
    .count (COUNT)
  );

  assign OUT_VALID                       = !empty;
  assign {OUT_UNIT, OUT_CARRY, OUT_DATA} = head;

  // When full the head is valid, so OUT_READY alone decides whether room opens up.
  assign ovf_drop = push_req && full && !OUT_READY;

  // A new error event outranks a simultaneous clear.
  always_ff @(posedge CLK) begin
    if (RST) begin
      OVERFLOW  <= 1'b0;
      MULTI_ERR <= 1'b0;
    end else begin
      if (ovf_drop)     OVERFLOW <= 1'b1;
      else if (CLR_ERR) OVERFLOW <= 1'b0;
      if (multi)        MULTI_ERR <= 1'b1;
      else if (CLR_ERR) MULTI_ERR <= 1'b0;
    end
  end

`ifdef ALU_COLLECT_DROPCNT_EN
  logic drop_any;
  assign drop_any = ovf_drop || multi;

  always_ff @(posedge CLK) begin
    if (RST)                             DROP_CNT <= 8'd0;
    else if (CLR_ERR)                    DROP_CNT <= {7'd0, drop_any};
    else if (drop_any && DROP_CNT != 8'hFF) DROP_CNT <= DROP_CNT + 8'd1;
  end
`endif

endmodule

// File: tb/tb_alu_result_collector.sv
// Directed + randomized bench for alu_result_collector against a queue-based reference model.
module tb_alu_result_collector;
  localparam int DW    = 8;
  localparam int DEPTH = 4;

  logic          CLK = 1'b0;
  logic          RST;
  logic [DW-1:0] Arith_OUT, Logic_OUT, CMP_OUT, Shift_OUT;
  logic          Carry_OUT;
  logic          Arith_Flag, Logic_Flag, CMP_Flag, Shift_Flag;
  logic          CLR_ERR, OUT_READY;
  logic          OUT_VALID;
  logic [DW-1:0] OUT_DATA;
  logic          OUT_CARRY;
  logic [1:0]    OUT_UNIT;
  logic [$clog2(DEPTH):0] COUNT;
  logic          OVERFLOW, MULTI_ERR;
`ifdef ALU_COLLECT_DROPCNT_EN
  logic [7:0]    DROP_CNT;
`endif

  alu_result_collector #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
    .CLK(CLK), .RST(RST),
    .Arith_OUT(Arith_OUT), .Logic_OUT(Logic_OUT), .CMP_OUT(CMP_OUT), .Shift_OUT(Shift_OUT),
    .Carry_OUT(Carry_OUT),
    .Arith_Flag(Arith_Flag), .Logic_Flag(Logic_Flag), .CMP_Flag(CMP_Flag), .Shift_Flag(Shift_Flag),
    .CLR_ERR(CLR_ERR), .OUT_READY(OUT_READY),
    .OUT_VALID(OUT_VALID), .OUT_DATA(OUT_DATA), .OUT_CARRY(OUT_CARRY), .OUT_UNIT(OUT_UNIT),
    .COUNT(COUNT), .OVERFLOW(OVERFLOW), .MULTI_ERR(MULTI_ERR)
`ifdef ALU_COLLECT_DROPCNT_EN
    , .DROP_CNT(DROP_CNT)
`endif
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int unsigned data;
    int unsigned carry;
    int unsigned unit;
  } ment_t;

  ment_t       q[$];
  bit          m_ovf, m_merr;
  int unsigned m_dc;
  int          n_tests = 0;
  int          n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [3:0] fl, input logic [DW-1:0] a, l, c, s,
                       input logic cy, input logic rdy, input logic clr);
    {Shift_Flag, CMP_Flag, Logic_Flag, Arith_Flag} = fl;
    Arith_OUT = a; Logic_OUT = l; CMP_OUT = c; Shift_OUT = s;
    Carry_OUT = cy; OUT_READY = rdy; CLR_ERR = clr;
  endtask

  // One clock: model consumes the inputs seen at the edge, then outputs are compared.
  task automatic cyc();
    logic [3:0]  fl;
    int          nf;
    bit          pop, push, ovf_drop, drop;
    ment_t       e;
    fl  = {Shift_Flag, CMP_Flag, Logic_Flag, Arith_Flag};
    nf  = $countones(fl);
    pop = OUT_READY && (q.size() > 0);
    e   = '{0, 0, 0};
    for (int i = 0; i < 4; i++) if (fl[i]) e.unit = i;
    case (e.unit)
      0: e.data = Arith_OUT;
      1: e.data = Logic_OUT;
      2: e.data = CMP_OUT;
      default: e.data = Shift_OUT;
    endcase
    e.carry = (e.unit == 0) ? Carry_OUT : 0;
    @(posedge CLK);
    if (RST) begin
      q.delete(); m_ovf = 0; m_merr = 0; m_dc = 0;
    end else begin
      push     = (nf == 1);
      ovf_drop = push && (q.size() == DEPTH) && !pop;
      drop     = ovf_drop || (nf > 1);
      if (pop) void'(q.pop_front());
      if (push && !ovf_drop) q.push_back(e);
      if (ovf_drop) m_ovf = 1; else if (CLR_ERR) m_ovf = 0;
      if (nf > 1) m_merr = 1; else if (CLR_ERR) m_merr = 0;
      if (CLR_ERR) m_dc = drop ? 1 : 0;
      else if (drop && m_dc < 255) m_dc++;
    end
    #1;
    chk("valid", OUT_VALID, q.size() > 0);
    chk("data",  OUT_DATA,  q.size() > 0 ? q[0].data  : 0);
    chk("carry", OUT_CARRY, q.size() > 0 ? q[0].carry : 0);
    chk("unit",  OUT_UNIT,  q.size() > 0 ? q[0].unit  : 0);
    chk("count", COUNT, q.size());
    chk("overflow", OVERFLOW, m_ovf);
    chk("multi_err", MULTI_ERR, m_merr);
`ifdef ALU_COLLECT_DROPCNT_EN
    chk("drop_cnt", DROP_CNT, m_dc);
`endif
  endtask

  initial begin
    logic [3:0] fl;
    int         r;
    RST = 1'b1;
    drive(4'b0000, '0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
    cyc();
    RST = 1'b0;
    cyc();

    // Single arith push, then drain
    drive(4'b0001, 8'hF0, 8'h0A, 8'h0B, 8'h0C, 1'b1, 1'b0, 1'b0); cyc();
    chk("first_push_data", OUT_DATA, 8'hF0);
    drive(4'b0000, '0, '0, '0, '0, 1'b0, 1'b1, 1'b0); cyc();

    // Fill with consumer stalled, then overflow
    drive(4'b0010, 8'h01, 8'h11, 8'h02, 8'h03, 1'b1, 1'b0, 1'b0); cyc();
    drive(4'b0100, 8'h01, 8'h02, 8'h22, 8'h03, 1'b1, 1'b0, 1'b0); cyc();
    drive(4'b1000, 8'h01, 8'h02, 8'h03, 8'h33, 1'b1, 1'b0, 1'b0); cyc();
    drive(4'b0001, 8'h44, 8'h02, 8'h03, 8'h04, 1'b0, 1'b0, 1'b0); cyc();
    drive(4'b0001, 8'h55, 8'h02, 8'h03, 8'h04, 1'b1, 1'b0, 1'b0); cyc();
    chk("full_count", COUNT, DEPTH);
    chk("overflow_set", OVERFLOW, 1'b1);
    // Push and pop while full
    drive(4'b1000, 8'h01, 8'h02, 8'h03, 8'h66, 1'b0, 1'b1, 1'b0); cyc();
    drive(4'b0000, '0, '0, '0, '0, 1'b0, 1'b1, 1'b0);
    repeat (DEPTH + 1) cyc();

    // Multi-flag error, then clear
    drive(4'b0101, 8'h77, 8'h02, 8'h88, 8'h04, 1'b1, 1'b0, 1'b0); cyc();
    chk("multi_set", MULTI_ERR, 1'b1);
    drive(4'b0000, '0, '0, '0, '0, 1'b0, 1'b0, 1'b1); cyc();
    chk("multi_clr", MULTI_ERR, 1'b0);

    // Streaming push+pop across pointer wrap
    drive(4'b0010, '0, 8'h90, '0, '0, 1'b0, 1'b1, 1'b0); cyc();
    for (int i = 0; i < 2*DEPTH+1; i++) begin
      drive(4'b0010, '0, 8'(8'hA0 + i), '0, '0, 1'b0, 1'b1, 1'b0); cyc();
    end
    drive(4'b0000, '0, '0, '0, '0, 1'b0, 1'b1, 1'b0); cyc();

    // COUNT=3 with OVERFLOW set, then reset
    for (int i = 0; i < DEPTH + 1; i++) begin
      drive(4'b1000, '0, '0, '0, 8'(8'hC0 + i), 1'b0, 1'b0, 1'b0); cyc();
    end
    drive(4'b0000, '0, '0, '0, '0, 1'b0, 1'b1, 1'b0); cyc();
    chk("pre_reset_count", COUNT, 3);
    RST = 1'b1; drive(4'b0001, 8'hEE, '0, '0, '0, 1'b1, 1'b0, 1'b0); cyc();
    RST = 1'b0;
    chk("reset_count", COUNT, 0);
    chk("reset_ovf", OVERFLOW, 1'b0);

    // Sustained multi-flag drops to exercise counter saturation
    for (int i = 0; i < 260; i++) begin
      drive(4'b1100, '0, '0, '0, '0, 1'b0, 1'b0, 1'b0); cyc();
    end
    drive(4'b0110, '0, '0, '0, '0, 1'b0, 1'b0, 1'b1); cyc();
    drive(4'b0000, '0, '0, '0, '0, 1'b0, 1'b0, 1'b1); cyc();

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      r = $urandom_range(0, 9);
      if (r < 3) fl = 4'b0000;
      else if (r < 9) fl = 4'(1 << $urandom_range(0, 3));
      else begin
        fl = 4'($urandom_range(0, 15));
        if ($countones(fl) < 2) fl = 4'b1010;
      end
      drive(fl, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 1'($urandom),
            (i % 100 < 50) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0),
            $urandom_range(0, 15) == 0);
      RST = ($urandom_range(0, 99) == 0);
      cyc();
    end
    RST = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
